riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit controller between the core's execute stage and the data-memory port. It accepts one memory operation per instruction, as decoded into request, write-enable and size. It holds the pipeline with a stall request until the memory handshake completes. It generates byte enables and lane-replicated write data, and returns sign- or zero-extended load data to the write-back mux.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  core clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lsu_req_i  in  1  core requests a memory operation (decoder mem_req)
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  3  size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- lsu_addr_i  in  32  byte address from ALU
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  extended load result, registered
- lsu_stall_req_o  out  1  hold PC/pipeline while 1
- data_req_o  out  1  memory request, registered
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word address {addr[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_rdata_i  in  32  memory read word
- data_ack_i  in  1  memory accepted/completed request this cycle
- lsu_misalign_o  out  1  present only with LSU_MISALIGN_TRAP_EN

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On lsu_req_i=1, latch addr, we, size and wdata, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - data_req_o=1 and memory outputs are driven from the latched values.
  - On data_ack_i=1, for loads register the formatted data_rdata_i into lsu_data_o; then go to DONE.
  - Without ack, stay in REQ with outputs stable. There is no timeout.
- DONE:
  - One cycle; go to IDLE unconditionally.
  - lsu_req_i still high in DONE (same instruction) is ignored and does not reissue.
- lsu_stall_req_o is combinational: (IDLE & lsu_req_i) | REQ. It is 0 in DONE and in IDLE without a request.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
  - Codes 3, 6, 7 are treated as B.
- Write data:
  - B: {4{d[7:0]}}.
  - H: {2{d[15:0]}}.
  - W: d.
- Load extraction:
  - Select the lane by addr[1:0] (B) or addr[1] (H).
  - B/H sign-extend; BU/HU zero-extend.
- lsu_data_o holds its value across stores and idle cycles. It changes only on a load ack.
- data_we_o, data_be_o, data_addr_o and data_wdata_o are 0 whenever data_req_o=0.

## Timing
- Reset values:
  - State IDLE.
  - lsu_data_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o and lsu_misalign_o all 0.
- Best case (ack in first REQ cycle): the request is seen in cycle 0, data_req_o rises in cycle 1, and DONE is in cycle 2. The instruction occupies 3 cycles, with stall high in cycles 0–1.
- Each wait cycle without ack adds one cycle of stall.
- data_ack_i outside REQ is ignored.
- Reset asserted in REQ: data_req_o drops immediately (asynchronously), and the operation is discarded.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A request is misaligned if it is H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned request goes IDLE→DONE directly and never asserts data_req_o.
  - lsu_misalign_o=1 for that DONE cycle only; lsu_data_o is unchanged.
- Undefined:
  - No lsu_misalign_o port.
  - Address bits below the access size are ignored: W uses the word, H uses addr[1] only.

## Test plan
- Store word: addr 0x100, data 0xDEADBEEF, ack in first REQ cycle → data_be_o=4'b1111, data_addr_o=0x100, data_wdata_o=0xDEADBEEF; stall high exactly 2 cycles.
- Store byte: addr 0x103, data 0x000000A5 → data_be_o=4'b1000, data_wdata_o=0xA5A5A5A5.
- Loads with rdata=0x80FF7F01, 3 wait cycles:
  - LB at addr 0x202 → lsu_data_o=0xFFFFFFFF.
  - LBU at addr 0x203 → 0x00000080.
  - LH at addr 0x202 → 0xFFFF80FF.
  - Stall high 5 cycles.
- Back-to-back load then store with lsu_req_i held through DONE → exactly two data_req_o episodes; no reissue in DONE; lsu_data_o unchanged by the store.
- Reset pulse while in REQ with no ack → data_req_o falls in the same cycle; all outputs 0; next request starts cleanly from IDLE.
- With LSU_MISALIGN_TRAP_EN, LW at addr 0x201 → data_req_o never asserts; lsu_misalign_o=1 for one cycle; stall high 1 cycle.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one memory op per instruction, stalls the core until the data port acks.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W requests skip the bus and pulse lsu_misalign_o.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_ack_i
`ifdef LSU_MISALIGN_TRAP_EN
   ,output logic        lsu_misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_req;
    logic [31:0] r_rdata;
    logic        w_in_mis;

    logic        w_is_w, w_is_h, w_unsigned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;
    always_comb begin
        w_in_mis = 1'b0;
        if (lsu_size_i == 3'd1 || lsu_size_i == 3'd5)
            w_in_mis = lsu_addr_i[0];
        else if (lsu_size_i == 3'd2)
            w_in_mis = |lsu_addr_i[1:0];
    end
    assign lsu_misalign_o = r_mis;
`else
    assign w_in_mis = 1'b0;
`endif

    // Size decode of the latched op; unused codes 3/6/7 fall through to signed byte.
    assign w_is_w     = (r_size == 3'd2);
    assign w_is_h     = (r_size == 3'd1) || (r_size == 3'd5);
    assign w_unsigned = (r_size == 3'd4) || (r_size == 3'd5);

    always_comb begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
        if (w_is_w) begin
            w_be    = 4'b1111;
            w_wdata = r_wdata;
        end else if (w_is_h) begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
        end
    end

    always_comb begin
        w_byte = data_rdata_i[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = data_rdata_i[15:8];
            2'd2:    w_byte = data_rdata_i[23:16];
            2'd3:    w_byte = data_rdata_i[31:24];
            default: w_byte = data_rdata_i[7:0];
        endcase
        w_half = r_addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        if (w_is_w)
            w_load = data_rdata_i;
        else if (w_is_h)
            w_load = {{16{w_half[15] & ~w_unsigned}}, w_half};
        else
            w_load = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
    end

    always_comb begin
        w_next          = r_state;
        lsu_stall_req_o = 1'b0;
        case (r_state)
            IDLE: begin
                lsu_stall_req_o = lsu_req_i;
                if (lsu_req_i)
                    w_next = w_in_mis ? DONE : REQ;
            end
            REQ: begin
                lsu_stall_req_o = 1'b1;
                if (data_ack_i)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == REQ);
            if (r_state == IDLE && lsu_req_i) begin
                r_addr  <= lsu_addr_i;
                r_we    <= lsu_we_i;
                r_size  <= lsu_size_i;
                r_wdata <= lsu_data_i;
            end
            if (r_state == REQ && data_ack_i && !r_we)
                r_rdata <= w_load;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_mis <= 1'b0;
        else       r_mis <= (r_state == IDLE) && lsu_req_i && w_in_mis;
    end
`endif

    // Bus fields are forced to zero outside an active request.
    assign data_req_o   = r_req;
    assign data_we_o    = r_req & r_we;
    assign data_be_o    = r_req ? w_be : 4'b0000;
    assign data_addr_o  = r_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign data_wdata_o = r_req ? w_wdata : 32'h0;
    assign lsu_data_o   = r_rdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against a transaction-level model of the LSU rules.
module tb_riscv_lsu;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic        data_ack_i;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        lsu_misalign_o;
`endif

    riscv_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
        .lsu_stall_req_o(lsu_stall_req_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i)
`ifdef LSU_MISALIGN_TRAP_EN
       ,.lsu_misalign_o(lsu_misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit f_isw(input logic [2:0] sz); return sz == 3'd2; endfunction
    function automatic bit f_ish(input logic [2:0] sz); return sz == 3'd1 || sz == 3'd5; endfunction

    function automatic bit f_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f_ish(sz)) return a[0];
        if (f_isw(sz)) return a[1:0] != 2'd0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] sz, input logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (f_isw(sz)) return 4'hF;
        if (f_ish(sz)) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'(1 << lane);
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] sz, input logic [31:0] d);
        int unsigned b, h;
        b = d % 256;
        h = d % 65536;
        if (f_isw(sz)) return d;
        if (f_ish(sz)) return h * 65537;
        return b * 32'h01010101;
    endfunction

    function automatic logic [31:0] f_ld(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
        int unsigned v, lane;
        lane = a % 4;
        if (f_isw(sz)) return rd;
        if (f_ish(sz)) begin
            v = (rd / ((lane >= 2) ? 65536 : 1)) % 65536;
            if (sz != 3'd5 && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = (rd / (1 << (8 * lane))) % 256;
            if (sz != 3'd4 && v >= 128) v = v + 32'hFFFFFF00;
        end
        return v;
    endfunction

    // One instruction: request held until its DONE cycle; memory acks after 'waits' idle REQ cycles.
    task automatic do_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input int waits, input logic [31:0] rd);
        int  n_st, n_rq, n_mis;
        bit  fin, mis;
        n_st = 0; n_rq = 0; n_mis = 0; fin = 0;
        mis = f_mis(sz, a);
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz;
        lsu_addr_i = a; lsu_data_i = d; data_rdata_i = rd;
        #1;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (c > 0) begin @(negedge clk_i); #1; end
            if (lsu_stall_req_o) n_st++;
            else if (c > 0) fin = 1;
`ifdef LSU_MISALIGN_TRAP_EN
            if (lsu_misalign_o) n_mis++;
`endif
            if (data_req_o) begin
                n_rq++;
                chk("addr", data_addr_o, {a[31:2], 2'b00});
                chk("be", 32'(data_be_o), 32'(f_be(sz, a)));
                chk("we", 32'(data_we_o), 32'(we));
                if (we) chk("wdata", data_wdata_o, f_wd(sz, d));
                data_ack_i = (n_rq == waits + 1);
            end else begin
                chk("idle_zero", 32'(data_we_o | (|data_be_o) | (|data_addr_o) | (|data_wdata_o)), 32'd0);
                data_ack_i = 1'($urandom_range(0, 1));
            end
        end
        data_ack_i = 1'b0;
        if (!we && !mis) m_data = f_ld(sz, a, rd);
        chk("done_reached", 32'(fin), 32'd1);
        chk("stall_cycles", n_st, mis ? 1 : waits + 2);
        chk("req_cycles", n_rq, mis ? 0 : waits + 1);
        chk("misalign_cycles", n_mis, mis ? 1 : 0);
        chk("load_data", lsu_data_o, m_data);
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        #1;
        chk("no_reissue", 32'(data_req_o), 32'd0);
        chk("idle_stall", 32'(lsu_stall_req_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0;
        lsu_addr_i = 0; lsu_data_i = 0; data_rdata_i = 0; data_ack_i = 0;
        m_data = 32'h0;
        @(negedge clk_i); #1;
        chk("rst_data", lsu_data_o, 32'h0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_bus", 32'(data_we_o | (|data_be_o) | (|data_addr_o) | (|data_wdata_o)), 32'd0);
        chk("rst_stall", 32'(lsu_stall_req_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        idle_cycle();
        do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 32'h0);
        idle_cycle();
        do_op(1'b0, 3'd0, 32'h202, 32'h0, 3, 32'h80FF7F01);
        chk("lb_val", lsu_data_o, 32'hFFFFFFFF);
        do_op(1'b0, 3'd4, 32'h203, 32'h0, 3, 32'h80FF7F01);
        chk("lbu_val", lsu_data_o, 32'h00000080);
        do_op(1'b0, 3'd1, 32'h202, 32'h0, 3, 32'h80FF7F01);
        chk("lh_val", lsu_data_o, 32'hFFFF80FF);
        do_op(1'b1, 3'd2, 32'h300, 32'h12345678, 1, 32'h0);
        chk("store_keeps_data", lsu_data_o, 32'hFFFF80FF);
        idle_cycle();

        // Reset in the middle of an unacknowledged request.
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h400;
        @(negedge clk_i); #1;
        chk("pre_rst_req", 32'(data_req_o), 32'd1);
        lsu_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        m_data = 32'h0;
        chk("rst_mid_req", 32'(data_req_o), 32'd0);
        chk("rst_mid_bus", 32'(data_we_o | (|data_be_o) | (|data_addr_o) | (|data_wdata_o)), 32'd0);
        chk("rst_mid_data", lsu_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_op(1'b0, 3'd5, 32'h502, 32'h0, 0, 32'hA55A1234);
        chk("post_rst_lhu", lsu_data_o, 32'h0000A55A);

`ifdef LSU_MISALIGN_TRAP_EN
        do_op(1'b0, 3'd2, 32'h201, 32'h0, 0, 32'hCAFEF00D);
        chk("mis_data_kept", lsu_data_o, 32'h0000A55A);
`endif

        for (int i = 0; i < 150; i++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  $urandom, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
